// File: rtl/cpu_pkg.sv
// Shared definitions for the unpipelined processor: fetch FSM state encoding,
// major opcode values and the default reset program counter.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: sequential, taken-branch and jump targets.
// All arithmetic wraps modulo 2^PC_WIDTH.
module pc_next #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [25:0]         jump_target_i,
  input  logic [31:0]         branch_offset_i,
  input  logic                branch_i,
  input  logic                jump_i,
  input  logic                zero_i,
  output logic [PC_WIDTH-1:0] pc_plus4_o,
  output logic [PC_WIDTH-1:0] next_pc_o
);

  logic [PC_WIDTH-1:0] branchTarget;
  logic [PC_WIDTH-1:0] jumpTarget;

  assign pc_plus4_o   = pc_i + PC_WIDTH'(4);
  // Offset is a word count; scale to bytes keeping its sign.
  assign branchTarget = pc_plus4_o + PC_WIDTH'(signed'(branch_offset_i) <<< 2);
  assign jumpTarget   = {pc_plus4_o[PC_WIDTH-1:28], jump_target_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jump_i) begin
      next_pc_o = jumpTarget;
    end else if (branch_i && zero_i) begin
      next_pc_o = branchTarget;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the unpipelined CPU: PC register, req/ack instruction fetch,
// instruction register held through execute, and the PC commit at end of execute.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Branch,
  input  logic                Jump,
  input  logic                Zero,
  input  logic [31:0]         BranchOffset,
  input  logic                Hold,
  input  logic [31:0]         IMemRdata,
  input  logic                IMemAck,
  output logic                IMemReq,
  output logic [PC_WIDTH-1:0] IMemAddr,
  output logic [31:0]         Instruction,
  output logic [5:0]          Opcode,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus4,
  output logic                InstrValid
);

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [31:0]         instr_q;
  logic                req_q;
  logic                valid_q;

  pc_next #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_next (
    .pc_i           (pc_q),
    .jump_target_i  (instr_q[25:0]),
    .branch_offset_i(BranchOffset),
    .branch_i       (Branch),
    .jump_i         (Jump),
    .zero_i         (Zero),
    .pc_plus4_o     (PCPlus4),
    .next_pc_o      (pc_d)
  );

  // Request and valid are registered alongside the state so they change only at
  // edges, except that reset clears them immediately and abandons any fetch.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (IMemAck) begin
            instr_q <= IMemRdata;
            state_q <= S_EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!Hold) begin
            pc_q    <= pc_d;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_RESET;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IMemReq     = req_q;
  assign IMemAddr    = pc_q;
  assign PC          = pc_q;
  assign Instruction = instr_q;
  assign Opcode      = opcode_of(instr_q);
  assign InstrValid  = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a random
// instruction stream checked against an arithmetic next-PC reference model.
module tb_instruction_fetch;
  import cpu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Branch = 1'b0;
  logic        Jump = 1'b0;
  logic        Zero = 1'b0;
  logic        Hold = 1'b0;
  logic        IMemAck = 1'b0;
  logic [31:0] BranchOffset = '0;
  logic [31:0] IMemRdata = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] Instruction;
  logic [5:0]  Opcode;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;

  int          total = 0;
  int          bad = 0;
  logic [31:0] modelPc;

  instruction_fetch #(
    .PC_WIDTH(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Branch      (Branch),
    .Jump        (Jump),
    .Zero        (Zero),
    .BranchOffset(BranchOffset),
    .Hold        (Hold),
    .IMemRdata   (IMemRdata),
    .IMemAck     (IMemAck),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .Instruction (Instruction),
    .Opcode      (Opcode),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .InstrValid  (InstrValid)
  );

  always #5 Clk = ~Clk;

  // Reference: next PC from the architectural rules, with plain 32-bit arithmetic.
  function automatic logic [31:0] refNextPc(input logic [31:0] pc, input logic [31:0] instr,
                                            input logic br, input logic jp, input logic z,
                                            input logic [31:0] off);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
    if (br && z) return seq + off * 32'd4;
    return seq;
  endfunction

  // Word offset that makes a taken branch at pc land on target.
  function automatic logic [31:0] offsetTo(input logic [31:0] pc, input logic [31:0] target);
    logic [31:0] diff;
    diff = target - pc - 32'd4;
    return {{2{diff[31]}}, diff[31:2]};
  endfunction

  // Answers the next request after `waits` idle cycles; reports the address and
  // whether req/addr stayed stable. Called and returns at a falling edge.
  task automatic serveFetch(input logic [31:0] word, input int waits,
                            output logic [31:0] addr, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (IMemReq !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (IMemReq !== 1'b1) begin
      ok = 1'b0;
      addr = 32'hxxxx_xxxx;
      return;
    end
    addr = IMemAddr;
    for (int i = 0; i < waits; i++) begin
      @(negedge Clk);
      if (IMemReq !== 1'b1 || IMemAddr !== addr) ok = 1'b0;
    end
    IMemAck = 1'b1;
    IMemRdata = word;
    @(negedge Clk);
    IMemAck = 1'b0;
    IMemRdata = $urandom;
  endtask

  // Spends holdCycles in execute with Hold high, then commits with the given controls.
  task automatic commit(input logic br, input logic jp, input logic z,
                        input logic [31:0] off, input int holdCycles);
    Hold = (holdCycles > 0);
    repeat (holdCycles) @(negedge Clk);
    Hold = 1'b0;
    Branch = br;
    Jump = jp;
    Zero = z;
    BranchOffset = off;
    @(negedge Clk);
    Branch = 1'b0;
    Jump = 1'b0;
    Zero = 1'b0;
    BranchOffset = $urandom;
  endtask

  task automatic doReset(input int cycles);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (cycles) @(negedge Clk);
    Rst = 1'b1;
    modelPc = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] addr;
    bit ok;
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    total++; if (PC !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h expected %h", PC, 32'h0); end
    total++; if (IMemReq !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b expected 0", IMemReq); end
    total++; if (InstrValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", InstrValid); end
    total++; if (Opcode !== 6'b0) begin bad++; $display("[TB] FAIL reset_opcode: got %b expected 000000", Opcode); end
    Rst = 1'b1;
    @(negedge Clk);
    total++; if (IMemReq !== 1'b1) begin bad++; $display("[TB] FAIL first_req: got %b expected 1", IMemReq); end
    serveFetch(32'h8C01_0004, 0, addr, ok);
    total++; if (!ok || addr !== 32'h0) begin bad++; $display("[TB] FAIL first_addr: got %h expected %h", addr, 32'h0); end
    total++; if (Opcode !== 6'b100011) begin bad++; $display("[TB] FAIL first_opcode: got %b expected 100011", Opcode); end
    total++; if (InstrValid !== 1'b1) begin bad++; $display("[TB] FAIL first_valid: got %b expected 1", InstrValid); end
    total++; if (IMemReq !== 1'b0) begin bad++; $display("[TB] FAIL req_drop: got %b expected 0", IMemReq); end
    commit(1'b0, 1'b0, 1'b0, 32'h0, 0);
    total++; if (InstrValid !== 1'b0) begin bad++; $display("[TB] FAIL valid_one_cycle: got %b expected 0", InstrValid); end
    total++; if (PC !== 32'h4) begin bad++; $display("[TB] FAIL first_commit_pc: got %h expected %h", PC, 32'h4); end
    modelPc = 32'h4;
  endtask

  task automatic test_sequential();
    logic [31:0] words [4];
    logic [31:0] addr;
    logic [31:0] w;
    bit ok;
    words[0] = 32'h8C22_0008;
    words[1] = 32'hAC23_000C;
    words[2] = 32'h0022_1820;
    words[3] = 32'h012A_4020;
    doReset(2);
    for (int i = 0; i < 4; i++) begin
      w = words[i];
      serveFetch(w, 3, addr, ok);
      total++; if (!ok || addr !== 32'(i * 4)) begin bad++; $display("[TB] FAIL seq_addr%0d: got %h expected %h stable=%0d", i, addr, 32'(i * 4), ok); end
      total++; if (Opcode !== w[31:26]) begin bad++; $display("[TB] FAIL seq_opcode%0d: got %b expected %b", i, Opcode, w[31:26]); end
      commit(1'b0, 1'b0, 1'b0, 32'h0, 0);
    end
    modelPc = 32'h10;
    total++; if (PC !== 32'h10) begin bad++; $display("[TB] FAIL seq_end_pc: got %h expected %h", PC, 32'h10); end
  endtask

  task automatic test_branch();
    logic [31:0] addr;
    bit ok;
    serveFetch({OP_BEQ, 26'h0001}, 0, addr, ok);
    commit(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 0);
    total++; if (PC !== 32'h04) begin bad++; $display("[TB] FAIL beq_taken: got %h expected %h", PC, 32'h04); end
    serveFetch({OP_J, 26'h4}, 1, addr, ok);
    commit(1'b0, 1'b1, 1'b0, 32'h0, 0);
    total++; if (PC !== 32'h10) begin bad++; $display("[TB] FAIL jump_back: got %h expected %h", PC, 32'h10); end
    serveFetch({OP_BEQ, 26'h0001}, 0, addr, ok);
    commit(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 0);
    total++; if (PC !== 32'h14) begin bad++; $display("[TB] FAIL beq_not_taken: got %h expected %h", PC, 32'h14); end
    modelPc = 32'h14;
  endtask

  task automatic test_jump_wrap();
    logic [31:0] addr;
    bit ok;
    serveFetch({OP_BEQ, 26'h0}, 0, addr, ok);
    commit(1'b1, 1'b0, 1'b1, offsetTo(modelPc, 32'h1000_0000), 0);
    total++; if (PC !== 32'h1000_0000) begin bad++; $display("[TB] FAIL far_branch: got %h expected %h", PC, 32'h1000_0000); end
    serveFetch({OP_J, 26'h000_0040}, 0, addr, ok);
    commit(1'b0, 1'b1, 1'b0, 32'h0, 0);
    total++; if (PC !== 32'h1000_0100) begin bad++; $display("[TB] FAIL jump_target: got %h expected %h", PC, 32'h1000_0100); end
    serveFetch({OP_J, 26'h000_0123}, 0, addr, ok);
    commit(1'b1, 1'b1, 1'b1, 32'h0000_0010, 0);
    total++; if (PC !== 32'h1000_048C) begin bad++; $display("[TB] FAIL jump_priority: got %h expected %h", PC, 32'h1000_048C); end
    serveFetch({OP_BEQ, 26'h0}, 0, addr, ok);
    commit(1'b1, 1'b0, 1'b1, offsetTo(32'h1000_048C, 32'hFFFF_FFFC), 0);
    total++; if (PC !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL to_top: got %h expected %h", PC, 32'hFFFF_FFFC); end
    serveFetch(32'h0022_1820, 0, addr, ok);
    commit(1'b0, 1'b0, 1'b0, 32'h0, 0);
    total++; if (PC !== 32'h0 || IMemAddr !== 32'h0) begin bad++; $display("[TB] FAIL wrap: got %h expected %h", PC, 32'h0); end
    modelPc = 32'h0;
  endtask

  task automatic test_hold_stray();
    logic [31:0] addr;
    logic [31:0] w;
    bit ok;
    w = 32'h8C44_0010;
    serveFetch(w, 2, addr, ok);
    Hold = 1'b1;
    Jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        IMemAck = 1'b1;
        IMemRdata = ~w;
      end
      @(negedge Clk);
      IMemAck = 1'b0;
      total++; if (PC !== modelPc || Opcode !== w[31:26] || InstrValid !== 1'b1 || IMemReq !== 1'b0)
        begin bad++; $display("[TB] FAIL hold%0d: got pc=%h op=%b v=%b req=%b expected pc=%h op=%b v=1 req=0", i, PC, Opcode, InstrValid, IMemReq, modelPc, w[31:26]); end
      total++; if (Instruction !== w) begin bad++; $display("[TB] FAIL stray_ack%0d: got %h expected %h", i, Instruction, w); end
    end
    Jump = 1'b0;
    commit(1'b0, 1'b0, 1'b0, 32'h0, 0);
    modelPc = modelPc + 32'd4;
    total++; if (PC !== modelPc) begin bad++; $display("[TB] FAIL hold_commit: got %h expected %h", PC, modelPc); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] addr;
    bit ok;
    serveFetch({OP_BEQ, 26'h0}, 0, addr, ok);
    commit(1'b1, 1'b0, 1'b1, offsetTo(modelPc, 32'h20), 0);
    total++; if (PC !== 32'h20 || IMemReq !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset: got pc=%h req=%b expected pc=%h req=1", PC, IMemReq, 32'h20); end
    #2 Rst = 1'b0;
    #1;
    total++; if (IMemReq !== 1'b0 || PC !== 32'h0) begin bad++; $display("[TB] FAIL async_reset: got pc=%h req=%b expected pc=%h req=0", PC, IMemReq, 32'h0); end
    IMemAck = 1'b1;
    IMemRdata = 32'hDEAD_BEEF;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    IMemAck = 1'b0;
    total++; if (Instruction !== 32'h0 || InstrValid !== 1'b0) begin bad++; $display("[TB] FAIL ack_in_reset: got ir=%h v=%b expected ir=%h v=0", Instruction, InstrValid, 32'h0); end
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin bad++; $display("[TB] FAIL restart: got req=%b addr=%h expected req=1 addr=%h", IMemReq, IMemAddr, 32'h0); end
    serveFetch(32'hAC05_0000, 1, addr, ok);
    commit(1'b0, 1'b0, 1'b0, 32'h0, 0);
    total++; if (PC !== 32'h4) begin bad++; $display("[TB] FAIL restart_commit: got %h expected %h", PC, 32'h4); end
    modelPc = 32'h4;
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] w;
    logic [31:0] off;
    logic [5:0]  ops [3];
    logic        br, jp, z;
    int          kind, waits, hold, tmp;
    bit          ok;
    ops[0] = OP_RTYPE;
    ops[1] = OP_LW;
    ops[2] = OP_SW;
    for (int i = 0; i < 40; i++) begin
      kind  = int'($urandom_range(0, 3));
      waits = int'($urandom_range(0, 3));
      hold  = int'($urandom_range(0, 2));
      tmp   = int'($urandom_range(0, 32)) - 16;
      off   = tmp;
      br = 1'b0; jp = 1'b0; z = 1'($urandom);
      case (kind)
        0: w = {ops[$urandom_range(0, 2)], 26'($urandom)};
        1: begin w = {OP_BEQ, 26'($urandom)}; br = 1'b1; end
        2: begin w = {OP_J, 26'($urandom)}; jp = 1'b1; end
        default: begin w = {OP_J, 26'($urandom)}; jp = 1'b1; br = 1'b1; z = 1'b1; end
      endcase
      serveFetch(w, waits, addr, ok);
      total++; if (!ok || addr !== modelPc) begin bad++; $display("[TB] FAIL rnd_addr%0d: got %h expected %h stable=%0d", i, addr, modelPc, ok); end
      total++; if (Opcode !== w[31:26]) begin bad++; $display("[TB] FAIL rnd_opcode%0d: got %b expected %b", i, Opcode, w[31:26]); end
      total++; if (PCPlus4 !== modelPc + 32'd4) begin bad++; $display("[TB] FAIL rnd_pcplus4_%0d: got %h expected %h", i, PCPlus4, modelPc + 32'd4); end
      commit(br, jp, z, off, hold);
      modelPc = refNextPc(modelPc, w, br, jp, z, off);
      total++; if (PC !== modelPc) begin bad++; $display("[TB] FAIL rnd_pc%0d: got %h expected %h", i, PC, modelPc); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_wrap();
    test_hold_stray();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Upstream neighbour of the `control` unit in the unpipelined processor. It holds the program counter and requests each instruction from instruction memory over a req/ack handshake. It latches the returned word into an instruction register, drives the opcode field to `control`, and holds it for the execute phase. At the end of execute it computes the next PC from `Branch`, `Jump` and the ALU `Zero` flag.

## Interface
- `PC_WIDTH`, 32: width of the PC and instruction memory address.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `Clk` input, 1: the single clock; all state updates on the rising edge.
- `Rst` input, 1: asynchronous, active-low reset (0 = reset asserted).
- `Branch` input, 1: from `control`; the current instruction is BEQ.
- `Jump` input, 1: from `control`; the current instruction is J.
- `Zero` input, 1: ALU equality flag for the current instruction.
- `BranchOffset` input, 32: sign-extended 16-bit immediate, in words.
- `Hold` input, 1: datapath extends execute (e.g. data memory busy).
- `IMemRdata` input, 32: instruction word from instruction memory.
- `IMemAck` input, 1: instruction memory accepted the request and `IMemRdata` is valid.
- `IMemReq` output, 1: fetch request.
- `IMemAddr` output, PC_WIDTH: fetch address, equal to `PC`.
- `Instruction` output, 32: instruction register.
- `Opcode` output, 6: `Instruction[31:26]`, wired to `control`.
- `PC` output, PC_WIDTH: address of the current instruction.
- `PCPlus4` output, PC_WIDTH: `PC + 4`, combinational (used by `control`/datapath).
- `InstrValid` output, 1: high while `Instruction` is being executed.

## Operation
- **States**:
  - **S_RESET**: entered asynchronously on reset. Moves to S_FETCH on the first edge after `Rst` returns to 1.
  - **S_FETCH**: `IMemReq` = 1. When `IMemAck` = 1 at an edge, `Instruction` <= `IMemRdata` and the state moves to S_EXEC. Otherwise the block stays in S_FETCH with `IMemAddr` held stable.
  - **S_EXEC**: `InstrValid` = 1 and `IMemReq` = 0.
    - If `Hold` = 1, the block stays in S_EXEC with PC and IR unchanged.
    - If `Hold` = 0, at the edge PC <= next PC and the state moves to S_FETCH.
- **Next PC** (evaluated only in S_EXEC with `Hold` = 0):
  - If `Jump`: `{PCPlus4[31:28], Instruction[25:0], 2'b00}`.
  - Else if `Branch && Zero`: `PCPlus4 + (BranchOffset << 2)`.
  - Else: `PCPlus4`.
- **Jump priority**: `Jump` has priority over `Branch` when both are asserted.
- **Arithmetic**: all PC arithmetic is modulo 2^PC_WIDTH. Wrap-around past 32'hFFFF_FFFC, or below 0 on a negative branch, is silent. `PC[1:0]` is always 00 by construction.
- **Ack outside S_FETCH**: `IMemAck` is ignored in S_RESET and S_EXEC. A stray ack never loads the IR.
- **`Branch`/`Jump`/`Zero` outside the commit edge**: ignored.
- **Reset mid-operation**: reset during S_FETCH abandons the request. `IMemReq` drops asynchronously and any ack arriving during or after reset is ignored. Reset during S_EXEC discards the instruction and does not update the PC.

## Timing
- **Reset values**:
  - `PC` = `RESET_PC`
  - `Instruction` = 32'h0000_0000, so `Opcode` = 6'b000000
  - `IMemReq` = 0
  - `InstrValid` = 0
  - state = S_RESET
- **First request**: `IMemReq` rises in the first cycle after reset release.
- **Fetch latency**: ack at edge N → IR valid and `InstrValid` = 1 from edge N until the commit edge.
- **Minimum instruction period**: 2 cycles. This occurs with ack in the first S_FETCH cycle and `Hold` = 0: one S_FETCH cycle plus one S_EXEC cycle.
- **Request handshake**: `IMemReq` and `IMemAddr` stay stable from assertion until the ack edge. `IMemReq` drops in the cycle after the ack edge.
- **Held outputs**: `Opcode`/`Instruction` are stable for the whole S_EXEC period, including Hold cycles, so `control` outputs are stable.
- **Outputs during fetch**: `PC` updates at the commit edge. `PCPlus4` follows `PC` combinationally.

## Structure
- **Shared package `cpu_pkg`**:
  - state encoding S_RESET/S_FETCH/S_EXEC
  - opcode constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010
  - default `RESET_PC`
- **Sub-module `pc_next`**: purely combinational next-PC mux and adders (inputs PC, Instruction, BranchOffset, Branch, Jump, Zero).
- **Top level**: the top holds the FSM, PC register and IR.

## Test plan
- **Reset and first fetch**: hold `Rst` = 0 for 2 cycles, then release with IMemRdata = 32'h8C01_0004 and ack in the first request cycle. Expect PC = 0, IMemReq = 0 during reset, Opcode = 100011 after the ack edge, and InstrValid high for one cycle.
- **Sequential flow with wait states**: ack delayed 3 cycles for each of four words (LW, SW, R-type, R-type). Expect IMemAddr 0, 4, 8, 12, held stable through each wait, and Opcode sequence 100011, 101011, 000000, 000000.
- **Branch taken/not taken**: BEQ at PC = 32'h10, BranchOffset = 32'hFFFF_FFFC, Zero = 1 → next PC = 32'h04. Repeat with Zero = 0 → next PC = 32'h14.
- **Jump, wrap and priority**:
  - J with target field 26'h000_0040 at PC = 32'h1000_0000 → next PC = 32'h1000_0100.
  - Jump and Branch both high → jump target wins.
  - PC = 32'hFFFF_FFFC sequential → next PC = 32'h0.
- **Hold and stray acks**: Hold = 1 for 3 cycles in S_EXEC → PC, Opcode and InstrValid unchanged, IMemReq = 0. IMemAck pulsed during S_EXEC with different data → Instruction unchanged.
- **Reset mid-fetch**: assert `Rst` = 0 asynchronously while IMemReq = 1 at PC = 32'h20. Expect IMemReq = 0 and PC = RESET_PC immediately, an ack during reset is ignored, and fetching restarts at RESET_PC after release.
